// File: rtl/reqack_arbiter.sv
// reqack_arbiter: round-robin arbiter and four-phase strobe sequencer for the
// shared request/acknowledge/data_enable/done bus. One winner at a time runs
// GRANT -> ACK -> DATA -> DONE. Back-to-back grants issue straight from DONE.
module reqack_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] done_o,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             request,
    output logic             acknowledge,
    output logic             data_enable,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_GRANT = 5'b00010,
        S_ACK   = 5'b00100,
        S_DATA  = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N_REQ);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [N_REQ-1:0] elig;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] nxt_ptr;
    logic [N_REQ-1:0] win_oh;
    logic             win_found;
    logic             start;

    // Eligible requests: only sampled in IDLE/DONE; in DONE the current
    // grantee still holds req_i, so its bit (the registered one-hot grant)
    // is masked out.
    always_comb begin
        elig = '0;
        if (state == S_IDLE) begin
            elig = req_i;
        end else if (state == S_DONE) begin
            elig = req_i & ~gnt_o;
        end
    end

    // Round-robin search upward from ptr, wrapping explicitly at N_REQ so
    // non-power-of-2 requester counts work.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < unsigned'(N_REQ); i++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= N_WIDE) begin
                cand = cand - N_WIDE;
            end
            if (!win_found && elig[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Winner one-hot, next pointer (explicit wrap) and grant decision.
    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
        nxt_ptr         = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        start           = enable && win_found;
    end

    // Sequencer FSM with every output held in a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            gnt_idx     <= '0;
            txn_count   <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            request     <= 1'b0;
            acknowledge <= 1'b0;
            data_enable <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            request     <= 1'b0;
            acknowledge <= 1'b0;
            data_enable <= 1'b0;
            done        <= 1'b0;
            done_o      <= '0;
            case (state)
                // IDLE and DONE share the grant decision; DONE also retires
                // the finished transaction.
                S_IDLE, S_DONE: begin
                    if (state == S_DONE) begin
                        txn_count <= txn_count + 1'b1;
                    end
                    if (start) begin
                        state   <= S_GRANT;
                        gnt_idx <= win_idx;
                        ptr     <= nxt_ptr;
                        gnt_o   <= win_oh;
                        request <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        gnt_o <= '0;
                        busy  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    state       <= S_ACK;
                    acknowledge <= 1'b1;
                end
                S_ACK: begin
                    state       <= S_DATA;
                    data_enable <= 1'b1;
                end
                S_DATA: begin
                    state  <= S_DONE;
                    done   <= 1'b1;
                    done_o <= gnt_o;
                end
                default: begin
                    state <= S_IDLE;
                    gnt_o <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reqack_arbiter.sv
// tb_reqack_arbiter: drives a 4-requester/16-bit-counter arbiter and a
// 3-requester/2-bit-counter arbiter, comparing both against a transaction-level
// model (phase number, winner, pointer, modular count) every cycle.
module tb_reqack_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, en4;
    logic [3:0] req4, gnt4, dn4;
    logic [1:0] idx4;
    logic       rq4o, ak4, de4, dd4, by4;
    logic [15:0] cnt4;

    logic       rst3, en3;
    logic [2:0] req3, gnt3, dn3;
    logic [1:0] idx3;
    logic       rq3o, ak3, de3, dd3, by3;
    logic [1:0] cnt3;

    reqack_arbiter #(.N_REQ(4), .CNT_W(16)) u_arb4 (
        .clk(clk), .rst_n(rst4), .enable(en4), .req_i(req4),
        .gnt_o(gnt4), .done_o(dn4), .gnt_idx(idx4),
        .request(rq4o), .acknowledge(ak4), .data_enable(de4), .done(dd4),
        .busy(by4), .txn_count(cnt4)
    );

    reqack_arbiter #(.N_REQ(3), .CNT_W(2)) u_arb3 (
        .clk(clk), .rst_n(rst3), .enable(en3), .req_i(req3),
        .gnt_o(gnt3), .done_o(dn3), .gnt_idx(idx3),
        .request(rq3o), .acknowledge(ak3), .data_enable(de3), .done(dd3),
        .busy(by3), .txn_count(cnt3)
    );

    logic [30:0] obs4;
    logic [14:0] obs3;
    assign obs4 = {gnt4, dn4, idx4, rq4o, ak4, de4, dd4, by4, cnt4};
    assign obs3 = {gnt3, dn3, idx3, rq3o, ak3, de3, dd3, by3, cnt3};

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = idle, 1..4 = request/ack/data/done cycle.
    int ph[2] = '{0, 0};
    int wn[2] = '{0, 0};
    int pt[2] = '{0, 0};
    int cn[2] = '{0, 0};

    function automatic void mstep(int d, logic [3:0] rq, logic en, logic rs);
        int n   = (d == 0) ? 4 : 3;
        int md  = (d == 0) ? 65536 : 4;
        int old = ph[d];
        bit found = 1'b0;
        int sel = 0;
        int c;
        if (!rs) begin
            ph[d] = 0; wn[d] = 0; pt[d] = 0; cn[d] = 0;
            return;
        end
        if (old == 4) cn[d] = (cn[d] + 1) % md;
        if (old == 0 || old == 4) begin
            for (int k = 0; k < n; k++) begin
                c = (pt[d] + k) % n;
                if (!found && rq[c[1:0]] && !(old == 4 && c == wn[d])) begin
                    found = 1'b1;
                    sel = c;
                end
            end
            if (en && found) begin
                ph[d] = 1; wn[d] = sel; pt[d] = (sel + 1) % n;
            end else begin
                ph[d] = 0;
            end
        end else begin
            ph[d] = old + 1;
        end
    endfunction

    function automatic logic [30:0] exp4();
        int p = ph[0];
        logic [3:0] oh;
        oh = (p != 0) ? 4'(1 << wn[0]) : 4'b0000;
        return {oh, (p == 4) ? oh : 4'b0000, 2'(wn[0]),
                p == 1, p == 2, p == 3, p == 4, p != 0, 16'(cn[0])};
    endfunction

    function automatic logic [14:0] exp3();
        int p = ph[1];
        logic [2:0] oh;
        oh = (p != 0) ? 3'(1 << wn[1]) : 3'b000;
        return {oh, (p == 4) ? oh : 3'b000, 2'(wn[1]),
                p == 1, p == 2, p == 3, p == 4, p != 0, 2'(cn[1])};
    endfunction

    // One clock: inputs are stable at the edge; outputs are sampled at negedge.
    task automatic cyc();
        @(posedge clk);
        mstep(0, req4, en4, rst4);
        mstep(1, {1'b0, req3}, en3, rst3);
        @(negedge clk);
    endtask

    task automatic reset4();
        rst4 = 1'b0; req4 = '0; en4 = 1'b1;
        cyc(); cyc();
        rst4 = 1'b1;
    endtask

    task automatic reset3();
        rst3 = 1'b0; req3 = '0; en3 = 1'b1;
        cyc(); cyc();
        rst3 = 1'b1;
    endtask

    // Bus protocol and one-hot monitors for both instances.
    a4_ra: assert property (@(posedge clk) (rst4 && rq4o) |=> ak4)
        else begin errors++; $display("FAIL sva4_req_ack got ack=%b exp 1", ak4); end
    a4_ad: assert property (@(posedge clk) (rst4 && ak4) |=> de4)
        else begin errors++; $display("FAIL sva4_ack_de got de=%b exp 1", de4); end
    a4_dd: assert property (@(posedge clk) (rst4 && de4) |=> dd4)
        else begin errors++; $display("FAIL sva4_de_done got done=%b exp 1", dd4); end
    a4_rr: assert property (@(posedge clk) (rst4 && rq4o) |=> !rq4o)
        else begin errors++; $display("FAIL sva4_req_twice got req=%b exp 0", rq4o); end
    a4_g1: assert property (@(posedge clk) rst4 |-> $onehot0(gnt4))
        else begin errors++; $display("FAIL sva4_gnt_onehot got %b exp onehot0", gnt4); end
    a4_s1: assert property (@(posedge clk) rst4 |-> $onehot0({rq4o, ak4, de4, dd4}))
        else begin errors++; $display("FAIL sva4_strobe_onehot got %b exp onehot0", {rq4o, ak4, de4, dd4}); end
    a3_ra: assert property (@(posedge clk) (rst3 && rq3o) |=> ak3)
        else begin errors++; $display("FAIL sva3_req_ack got ack=%b exp 1", ak3); end
    a3_ad: assert property (@(posedge clk) (rst3 && ak3) |=> de3)
        else begin errors++; $display("FAIL sva3_ack_de got de=%b exp 1", de3); end
    a3_dd: assert property (@(posedge clk) (rst3 && de3) |=> dd3)
        else begin errors++; $display("FAIL sva3_de_done got done=%b exp 1", dd3); end
    a3_rr: assert property (@(posedge clk) (rst3 && rq3o) |=> !rq3o)
        else begin errors++; $display("FAIL sva3_req_twice got req=%b exp 0", rq3o); end
    a3_g1: assert property (@(posedge clk) rst3 |-> $onehot0(gnt3))
        else begin errors++; $display("FAIL sva3_gnt_onehot got %b exp onehot0", gnt3); end
    a3_s1: assert property (@(posedge clk) rst3 |-> $onehot0({rq3o, ak3, de3, dd3}))
        else begin errors++; $display("FAIL sva3_strobe_onehot got %b exp onehot0", {rq3o, ak3, de3, dd3}); end

    task automatic test_reset();
        rst4 = 1'b0; rst3 = 1'b0; en4 = 1'b1; en3 = 1'b1;
        req4 = 4'b1111; req3 = 3'b111;
        cyc(); cyc();
        checks++; if (obs4 !== '0) begin errors++; $display("FAIL reset4 got %h exp 0", obs4); end
        checks++; if (obs3 !== '0) begin errors++; $display("FAIL reset3 got %h exp 0", obs3); end
        checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL reset4_model got %h exp %h", obs4, exp4()); end
        req4 = '0; req3 = '0;
        rst4 = 1'b1; rst3 = 1'b1;
        cyc();
        checks++; if (obs4 !== '0) begin errors++; $display("FAIL reset4_idle got %h exp 0", obs4); end
    endtask

    task automatic test_single();
        logic [3:0] es;
        reset4();
        req4 = 4'b0001;
        for (int t = 1; t <= 4; t++) begin
            cyc();
            es = 4'b1000 >> (t - 1);
            checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL single_model%0d got %h exp %h", t, obs4, exp4()); end
            checks++; if ({rq4o, ak4, de4, dd4} !== es) begin errors++; $display("FAIL single_strobe%0d got %b exp %b", t, {rq4o, ak4, de4, dd4}, es); end
            checks++; if (gnt4 !== 4'b0001) begin errors++; $display("FAIL single_gnt%0d got %b exp 0001", t, gnt4); end
        end
        checks++; if (dn4 !== 4'b0001) begin errors++; $display("FAIL single_done_o got %b exp 0001", dn4); end
        req4 = '0;
        cyc();
        checks++; if (cnt4 !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", cnt4); end
        checks++; if (by4 !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b exp 0", by4); end
        // pointer now 1: with clients 0 and 1 both asking, client 1 wins
        req4 = 4'b0011;
        cyc();
        checks++; if (idx4 !== 2'd1 || rq4o !== 1'b1) begin errors++; $display("FAIL single_ptr got idx=%0d req=%b exp idx=1 req=1", idx4, rq4o); end
        req4 = '0;
        for (int t = 0; t < 4; t++) begin
            cyc();
            checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL single_drain%0d got %h exp %h", t, obs4, exp4()); end
        end
    endtask

    task automatic test_all_requesting();
        int q[$];
        reset4();
        req4 = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            cyc();
            checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL allreq_model%0d got %h exp %h", c, obs4, exp4()); end
            checks++; if (by4 !== 1'b1) begin errors++; $display("FAIL allreq_gap%0d got busy=%b exp 1", c, by4); end
            checks++; if (rq4o !== (c % 4 == 0)) begin errors++; $display("FAIL allreq_spacing%0d got req=%b exp %b", c, rq4o, (c % 4 == 0)); end
            if (rq4o) q.push_back(int'(idx4));
            if (dn4 != 4'b0000) req4 = req4 & ~dn4;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q.size() || q[i] != i) begin
                errors++; $display("FAIL allreq_order%0d got %0d exp %0d", i, (i < q.size()) ? q[i] : -1, i);
            end
        end
        cyc();
        checks++; if (cnt4 !== 16'd4 || by4 !== 1'b0) begin errors++; $display("FAIL allreq_count got cnt=%0d busy=%b exp cnt=4 busy=0", cnt4, by4); end
    endtask

    task automatic test_wrap();
        logic [2:0] sch [4];
        int ew [4];
        int ec [4];
        int w;
        bit got;
        sch = '{3'b100, 3'b011, 3'b011, 3'b001};
        ew  = '{2, 0, 1, 0};
        ec  = '{1, 2, 3, 0};
        reset3();
        for (int s = 0; s < 4; s++) begin
            req3 = sch[s];
            got = 1'b0;
            w = -1;
            for (int c = 0; c < 8 && !got; c++) begin
                cyc();
                checks++; if (obs3 !== exp3()) begin errors++; $display("FAIL wrap_model%0d_%0d got %h exp %h", s, c, obs3, exp3()); end
                if (rq3o) w = int'(idx3);
                if (dn3 != 3'b000) got = 1'b1;
            end
            checks++; if (!got) begin errors++; $display("FAIL wrap_timeout%0d got no done exp done", s); end
            req3 = '0;
            cyc();
            checks++; if (w != ew[s]) begin errors++; $display("FAIL wrap_winner%0d got %0d exp %0d", s, w, ew[s]); end
            checks++; if (cnt3 !== 2'(ec[s])) begin errors++; $display("FAIL wrap_count%0d got %0d exp %0d", s, cnt3, ec[s]); end
        end
    endtask

    task automatic test_hold_through_done();
        reset4();
        req4 = 4'b0010;
        for (int t = 1; t <= 4; t++) begin
            cyc();
            checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL hold_model%0d got %h exp %h", t, obs4, exp4()); end
        end
        checks++; if (dd4 !== 1'b1) begin errors++; $display("FAIL hold_done got %b exp 1", dd4); end
        cyc();
        checks++; if (by4 !== 1'b0 || rq4o !== 1'b0) begin errors++; $display("FAIL hold_idle got busy=%b req=%b exp 0 0", by4, rq4o); end
        cyc();
        checks++; if (rq4o !== 1'b1 || idx4 !== 2'd1) begin errors++; $display("FAIL hold_regrant got req=%b idx=%0d exp 1 1", rq4o, idx4); end
        req4 = '0;
        for (int t = 0; t < 4; t++) begin
            cyc();
            checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL hold_drain%0d got %h exp %h", t, obs4, exp4()); end
        end
    endtask

    task automatic test_enable_drop();
        reset4();
        req4 = 4'b0100;
        cyc();
        checks++; if (rq4o !== 1'b1) begin errors++; $display("FAIL en_grant got %b exp 1", rq4o); end
        cyc();
        checks++; if (ak4 !== 1'b1) begin errors++; $display("FAIL en_ack got %b exp 1", ak4); end
        en4 = 1'b0;
        cyc();
        checks++; if (de4 !== 1'b1) begin errors++; $display("FAIL en_data got %b exp 1", de4); end
        cyc();
        checks++; if (dd4 !== 1'b1 || dn4 !== 4'b0100) begin errors++; $display("FAIL en_done got done=%b done_o=%b exp 1 0100", dd4, dn4); end
        for (int t = 0; t < 5; t++) begin
            cyc();
            checks++; if (by4 !== 1'b0 || rq4o !== 1'b0) begin errors++; $display("FAIL en_hold%0d got busy=%b req=%b exp 0 0", t, by4, rq4o); end
            checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL en_model%0d got %h exp %h", t, obs4, exp4()); end
        end
        en4 = 1'b1;
        cyc();
        checks++; if (rq4o !== 1'b1 || idx4 !== 2'd2) begin errors++; $display("FAIL en_resume got req=%b idx=%0d exp 1 2", rq4o, idx4); end
        req4 = '0;
        for (int t = 0; t < 4; t++) begin
            cyc();
            checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL en_drain%0d got %h exp %h", t, obs4, exp4()); end
        end
    endtask

    task automatic test_reset_mid();
        reset4();
        req4 = 4'b1000;
        for (int t = 1; t <= 4; t++) cyc();
        req4 = '0;
        cyc();
        checks++; if (cnt4 !== 16'd1) begin errors++; $display("FAIL rmid_first got cnt=%0d exp 1", cnt4); end
        req4 = 4'b1000;
        for (int t = 1; t <= 3; t++) begin
            cyc();
            checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL rmid_model%0d got %h exp %h", t, obs4, exp4()); end
        end
        checks++; if (de4 !== 1'b1) begin errors++; $display("FAIL rmid_data got %b exp 1", de4); end
        rst4 = 1'b0;
        cyc();
        checks++; if (obs4 !== '0) begin errors++; $display("FAIL rmid_abort got %h exp 0", obs4); end
        rst4 = 1'b1;
        req4 = '0;
        cyc();
        checks++; if (obs4 !== '0) begin errors++; $display("FAIL rmid_nodone got %h exp 0", obs4); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1200; c++) begin
            req4 = 4'($urandom);
            en4  = ($urandom_range(0, 7) != 0);
            rst4 = ($urandom_range(0, 63) != 0);
            req3 = 3'($urandom);
            en3  = ($urandom_range(0, 7) != 0);
            rst3 = ($urandom_range(0, 63) != 0);
            cyc();
            checks++; if (obs4 !== exp4()) begin errors++; $display("FAIL rand4_%0d got %h exp %h", c, obs4, exp4()); end
            checks++; if (obs3 !== exp3()) begin errors++; $display("FAIL rand3_%0d got %h exp %h", c, obs3, exp3()); end
        end
    endtask

    initial begin
        rst4 = 1'b0; rst3 = 1'b0; en4 = 1'b0; en3 = 1'b0; req4 = '0; req3 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_requesting();
        test_wrap();
        test_hold_through_done();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got still running exp finished");
        $fatal(1, "watchdog expired");
    end

endmodule
